// File: rtl/activation_store_pkg.sv
// Shared types for the dual-read activation store and its read sequencer.
package activation_store_pkg;

    localparam int unsigned VALUE_WIDTH   = 16;
    localparam int unsigned ADDRESS_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [VALUE_WIDTH-1:0] val1;
        logic [VALUE_WIDTH-1:0] val2;
        logic                   last;
    } pair_t;

endpackage

// File: rtl/activation_pair_reader_fifo.sv
// Small synchronous FIFO holding captured activation pairs; exposes its fill count.
module pair_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Storage carries no reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/activation_pair_reader.sv
// Streams LEN address pairs out of the dual-read activation store onto a
// valid/ready interface, absorbing the store's one-cycle read latency.
module activation_pair_reader
    import activation_store_pkg::*;
#(
    parameter int unsigned value_width   = VALUE_WIDTH,
    parameter int unsigned address_width = ADDRESS_WIDTH,
    parameter int unsigned fifo_depth    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [address_width-1:0] base1,
    input  logic [address_width-1:0] base2,
    input  logic [address_width:0]   len,
    output logic                     busy,
    output logic                     done,
    output logic                     st_wr_en,
    output logic [address_width-1:0] st_address1,
    output logic [address_width-1:0] st_address2,
    input  logic [value_width-1:0]   st_read_val1,
    input  logic [value_width-1:0]   st_read_val2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [value_width-1:0]   out_val1,
    output logic [value_width-1:0]   out_val2,
    output logic                     out_last
);

    localparam int unsigned CW = $clog2(fifo_depth) + 1;
    localparam logic [address_width:0] LEN_ONE = (address_width + 1)'(1);

    typedef struct packed {
        logic [value_width-1:0] val1;
        logic [value_width-1:0] val2;
        logic                   last;
    } entry_t;

    state_e                   state_q;
    logic [address_width-1:0] addr1_q;
    logic [address_width-1:0] addr2_q;
    logic [address_width-1:0] hold1_q;
    logic [address_width-1:0] hold2_q;
    logic [address_width:0]   remaining_q;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic                     busy_q;
    logic                     done_q;

    entry_t                   wr_entry;
    entry_t                   rd_entry;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic                     pop;
    logic                     issue;
    logic [CW:0]              credit_used;

    assign pop = !fifo_empty && out_ready;

    // A pop this cycle frees a slot before the read issued now is captured,
    // which is what sustains one pair per cycle with a two-entry buffer.
    assign credit_used = {1'b0, fifo_count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign issue       = (state_q == ISSUE) && (credit_used < (CW + 1)'(fifo_depth));

    assign st_wr_en    = 1'b0;
    assign st_address1 = issue ? addr1_q : hold1_q;
    assign st_address2 = issue ? addr2_q : hold2_q;

    assign wr_entry = '{val1: st_read_val1, val2: st_read_val2, last: inflight_last_q};

    pair_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_val1  = fifo_empty ? '0 : rd_entry.val1;
    assign out_val2  = fifo_empty ? '0 : rd_entry.val2;
    assign out_last  = !fifo_empty && rd_entry.last;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            addr1_q         <= '0;
            addr2_q         <= '0;
            hold1_q         <= '0;
            hold2_q         <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == LEN_ONE);
            if (issue) begin
                hold1_q     <= addr1_q;
                hold2_q     <= addr2_q;
                addr1_q     <= addr1_q + 1'b1;
                addr2_q     <= addr2_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr1_q     <= base1;
                            addr2_q     <= base2;
                            remaining_q <= len;
                            busy_q      <= 1'b1;
                            state_q     <= ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue && (remaining_q == LEN_ONE)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && rd_entry.last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_pair_reader.sv
// Directed bench for activation_pair_reader with a registered-read store model
// and a queue of expected pairs filled as each burst is started.
module tb_activation_pair_reader;
    import activation_store_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base1;
    logic [9:0]  base2;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        st_wr_en;
    logic [9:0]  st_address1;
    logic [9:0]  st_address2;
    logic [15:0] st_read_val1;
    logic [15:0] st_read_val2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_val1;
    logic [15:0] out_val2;
    logic        out_last;

    logic [15:0] mem [1024];

    pair_t sb[$];
    logic  model_busy;
    logic  done_exp;
    int    checks;
    int    errors;

    activation_pair_reader #(
        .value_width   (16),
        .address_width (10),
        .fifo_depth    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base1        (base1),
        .base2        (base2),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .st_wr_en     (st_wr_en),
        .st_address1  (st_address1),
        .st_address2  (st_address2),
        .st_read_val1 (st_read_val1),
        .st_read_val2 (st_read_val2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_val1     (out_val1),
        .out_val2     (out_val2),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int unsigned i = 0; i < 1024; i++) mem[i] = 16'(i);
    end

    always @(posedge clk) begin
        st_read_val1 <= mem[st_address1];
        st_read_val2 <= mem[st_address2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: checks current outputs, predicts the next edge.
    task automatic step(input logic rdy);
        logic  busy_next;
        logic  done_next;
        pair_t e;
        out_ready = rdy;
        busy_next = model_busy;
        done_next = 1'b0;
        chk("wr_en", 32'(st_wr_en), 32'd0);
        chk("busy", 32'(busy), 32'(model_busy));
        chk("done", 32'(done), 32'(done_exp));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb[0];
                chk("val1", 32'(out_val1), 32'(e.val1));
                chk("val2", 32'(out_val2), 32'(e.val2));
                chk("last", 32'(out_last), 32'(e.last));
                if (rdy) begin
                    void'(sb.pop_front());
                    if (e.last) begin
                        done_next = 1'b1;
                        busy_next = 1'b0;
                    end
                end
            end
        end
        if (start && !model_busy) begin
            if (len == '0) begin
                done_next = 1'b1;
            end else begin
                busy_next = 1'b1;
                for (int unsigned k = 0; k < 32'(len); k++) begin
                    logic [9:0] a1;
                    logic [9:0] a2;
                    a1 = base1 + 10'(k);
                    a2 = base2 + 10'(k);
                    e.val1 = {6'd0, a1};
                    e.val2 = {6'd0, a2};
                    e.last = (k == 32'(len) - 1);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        model_busy = busy_next;
        done_exp   = done_next;
    endtask

    task automatic run(input int unsigned max, input int unsigned mode);
        int unsigned n;
        logic rdy;
        n = 0;
        while ((sb.size() != 0 || model_busy || done_exp) && n < max) begin
            rdy = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            step(rdy);
            n++;
        end
        chk("timeout", 32'(n < max), 32'd1);
    endtask

    task automatic burst(input logic [9:0] b1, input logic [9:0] b2, input logic [10:0] l, input logic rdy);
        base1 = b1;
        base2 = b2;
        len   = l;
        start = 1'b1;
        step(rdy);
        start = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        model_busy = 1'b0;
        done_exp   = 1'b0;
        reset      = 1'b0;
        start      = 1'b0;
        base1      = '0;
        base2      = '0;
        len        = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr1", 32'(st_address1), 32'd0);
        chk("rst_addr2", 32'(st_address2), 32'd0);
        chk("rst_val1", 32'(out_val1), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        reset = 1'b1;
        step(1'b1);

        // Basic burst: latency, addresses on the issue cycle, full throughput.
        burst(10'd0, 10'd512, 11'd4, 1'b1);
        chk("t1_valid_c1", 32'(out_valid), 32'd0);
        chk("t1_issue_addr1", 32'(st_address1), 32'd0);
        chk("t1_issue_addr2", 32'(st_address2), 32'd512);
        step(1'b1);
        chk("t1_valid_c2", 32'(out_valid), 32'd0);
        step(1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            chk("t1_tput_valid", 32'(out_valid), 32'd1);
            step(1'b1);
        end
        run(10, 0);

        // Address wrap on stream 1.
        burst(10'd1022, 10'd5, 11'd4, 1'b1);
        run(40, 0);

        // Backpressure 1,0,0,1 over eight pairs.
        burst(10'd40, 10'd600, 11'd8, 1'b1);
        run(100, 1);

        // Zero-length start.
        burst(10'd3, 10'd4, 11'd0, 1'b1);
        run(5, 0);
        for (int unsigned i = 0; i < 3; i++) step(1'b1);

        // Start while busy is ignored.
        burst(10'd100, 10'd200, 11'd6, 1'b1);
        step(1'b1);
        step(1'b1);
        burst(10'd300, 10'd400, 11'd3, 1'b1);
        run(40, 0);
        for (int unsigned i = 0; i < 3; i++) step(1'b1);

        // Reset with a read in flight and a pair buffered.
        burst(10'd10, 10'd20, 11'd4, 1'b0);
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_addr1", 32'(st_address1), 32'd0);
        chk("mid_rst_val1", 32'(out_val1), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        sb.delete();
        model_busy = 1'b0;
        done_exp   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1);
        burst(10'd700, 10'd900, 11'd2, 1'b1);
        run(30, 0);
        for (int unsigned i = 0; i < 4; i++) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
